// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the execute stage, the pipeline sequencer and the PC / IF-ID registers.
// The slave modport is the sequencer; the master modport is the surrounding core (or a bench).
interface pipe_ctrl_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              jump_en;
   logic [ADDR_W-1:0] jump_addr;
   logic              hold_en;
   logic              fetch_ready;
   logic              halt_req;
   logic              halt_ack;
   logic              pc_jump_en;
   logic [ADDR_W-1:0] pc_jump_addr;
   logic              pc_hold;
   logic              ifid_flush;
   logic [1:0]        ctrl_state;

   modport master (
      output jump_en, jump_addr, hold_en, fetch_ready, halt_req,
      input  halt_ack, pc_jump_en, pc_jump_addr, pc_hold, ifid_flush, ctrl_state
   );

   modport slave (
      input  jump_en, jump_addr, hold_en, fetch_ready, halt_req,
      output halt_ack, pc_jump_en, pc_jump_addr, pc_hold, ifid_flush, ctrl_state
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 3-stage core: redirect bubbles, redirect buffering across fetch
// stalls and the debug halt handshake.
module pipe_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned ADDR_W       = 32
) (
   input logic        clk,
   input logic        rst,
   pipe_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      StRun   = 2'd0,
      StFlush = 2'd1,
      StPend  = 2'd2,
      StHalt  = 2'd3
   } state_e;

   localparam logic [3:0] CntLoad = 4'(FLUSH_CYCLES - 1);

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
   logic              halt_ack_q, halt_ack_d;

   logic              redirect;
   logic              pc_jump_en, pc_hold, ifid_flush;
   logic [ADDR_W-1:0] pc_jump_addr;

   assign redirect = bus.jump_en & bus.hold_en;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      pend_addr_d  = pend_addr_q;
      pc_jump_en   = 1'b0;
      pc_jump_addr = '0;
      pc_hold      = 1'b0;
      ifid_flush   = 1'b0;

      unique case (state_q)
         StRun: begin
            if (redirect && bus.fetch_ready) begin
               pc_jump_en   = 1'b1;
               pc_jump_addr = bus.jump_addr;
               ifid_flush   = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  state_d = StFlush;
                  cnt_d   = CntLoad;
               end
            end else if (redirect) begin
               pend_addr_d = bus.jump_addr;
               pc_hold     = 1'b1;
               ifid_flush  = 1'b1;
               state_d     = StPend;
            end else if (bus.halt_req) begin
               pc_hold    = 1'b1;
               ifid_flush = 1'b1;
               state_d    = StHalt;
            end else if (!bus.fetch_ready) begin
               pc_hold    = 1'b1;
               ifid_flush = 1'b1;
            end
         end
         StFlush: begin
            ifid_flush = 1'b1;
            pc_hold    = !bus.fetch_ready;
            // Bubbles only count when fetch actually delivers a (discarded) instruction.
            if (bus.fetch_ready) begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_d = StRun;
            end
         end
         StPend: begin
            ifid_flush = 1'b1;
            if (!bus.fetch_ready) begin
               pc_hold = 1'b1;
            end else begin
               pc_jump_en   = 1'b1;
               pc_jump_addr = pend_addr_q;
               if (FLUSH_CYCLES > 1) begin
                  state_d = StFlush;
                  cnt_d   = CntLoad;
               end else begin
                  state_d = StRun;
               end
            end
         end
         StHalt: begin
            pc_hold    = 1'b1;
            ifid_flush = 1'b1;
            if (!bus.halt_req) state_d = StRun;
         end
         default: state_d = StRun;
      endcase

      // Acknowledge only once HALT has been held across an edge.
      halt_ack_d = (state_q == StHalt) && (state_d == StHalt);

      if (rst) begin
         pc_jump_en   = 1'b0;
         pc_jump_addr = '0;
         pc_hold      = 1'b1;
         ifid_flush   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StRun;
         cnt_q       <= 4'd0;
         pend_addr_q <= '0;
         halt_ack_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pend_addr_q <= pend_addr_d;
         halt_ack_q  <= halt_ack_d;
      end
   end

   assign bus.pc_jump_en   = pc_jump_en;
   assign bus.pc_jump_addr = pc_jump_addr;
   assign bus.pc_hold      = pc_hold;
   assign bus.ifid_flush   = ifid_flush;
   assign bus.halt_ack     = halt_ack_q;
   assign bus.ctrl_state   = state_q;

endmodule
